// File: rtl/byte_deser_pkg.sv
// Shared types and defaults for the byte_deser serial-to-parallel front end.
// Optional parity support is selected with BYTE_DESER_PARITY_EN.
package byte_deser_pkg;

    localparam int BYTE_DESER_BITS_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } byte_deser_state_t;

    function automatic int deser_cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/byte_deser_shreg.sv
// Frame shift register plus bit counter for byte_deser; load starts a new frame
// with the current bit, shift appends it, clear zeroes the counter.
module deser_shreg
    import byte_deser_pkg::*;
#(
    parameter int BITS      = BYTE_DESER_BITS_DEF,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CW        = deser_cnt_width(BITS)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            bit_in,
    input  logic            load,
    input  logic            shift,
    input  logic            clear,
    output logic [BITS-1:0] word,
    output logic [CW-1:0]   count
);

    localparam logic [CW-1:0] CNT_FULL = CW'(BITS);

    logic [BITS-1:0] data;
    logic [BITS-1:0] first_val;
    logic [BITS-1:0] shift_val;

    always_comb begin
        if (MSB_FIRST) begin
            first_val = BITS'(bit_in);
            shift_val = (data << 1) | BITS'(bit_in);
        end else begin
            first_val = BITS'(bit_in) << (BITS - 1);
            shift_val = (data >> 1) | (BITS'(bit_in) << (BITS - 1));
        end
    end

    // word already includes the bit being shifted this cycle so a frame can
    // be handed off on the same edge that samples its last data bit
    assign word = shift ? shift_val : data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data  <= '0;
            count <= '0;
        end else if (load) begin
            data  <= first_val;
            count <= CW'(1);
        end else if (clear) begin
            count <= '0;
        end else if (shift) begin
            data <= shift_val;
            if (count != CNT_FULL) begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/byte_deser.sv
// Framed bit-serial to parallel converter feeding the ones counter's a input.
// Defining BYTE_DESER_PARITY_EN adds a trailing even-parity bit and parity_err.
//
// state  | meaning
// IDLE   | no frame open; waits for a valid bit with sin_sof
// SHIFT  | collecting data bits of the current frame
// PARITY | all data bits held; next valid bit is the parity bit
module byte_deser
    import byte_deser_pkg::*;
#(
    parameter int BITS      = BYTE_DESER_BITS_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sin,
    input  logic            sin_valid,
    input  logic            sin_sof,
    input  logic            a_ready,
    output logic [BITS-1:0] a,
    output logic            a_valid,
    output logic            drop,
`ifdef BYTE_DESER_PARITY_EN
    output logic            parity_err,
`endif
    output logic            overrun
);

    localparam int CW = deser_cnt_width(BITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);

    byte_deser_state_t state;

    logic            sr_load;
    logic            sr_shift;
    logic            sr_clear;
    logic [BITS-1:0] sr_word;
    logic [CW-1:0]   sr_count;
    logic            last_data;
    logic            frame_done;
    logic            par_bad;

    deser_shreg #(
        .BITS      (BITS),
        .MSB_FIRST (MSB_FIRST),
        .CW        (CW)
    ) u_shreg (
        .clk     (clk),
        .reset_n (reset_n),
        .bit_in  (sin),
        .load    (sr_load),
        .shift   (sr_shift),
        .clear   (sr_clear),
        .word    (sr_word),
        .count   (sr_count)
    );

    assign last_data = (sr_count == CNT_LAST);

    always_comb begin
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        sr_clear   = 1'b0;
        frame_done = 1'b0;
        par_bad    = 1'b0;
        if (sin_valid) begin
            if (sin_sof) begin
                sr_load = 1'b1;
            end else begin
                case (state)
                    SHIFT: begin
                        sr_shift = 1'b1;
`ifndef BYTE_DESER_PARITY_EN
                        frame_done = last_data;
`endif
                    end
`ifdef BYTE_DESER_PARITY_EN
                    PARITY: begin
                        sr_clear = 1'b1;
                        // even parity: data ones plus parity bit must be even
                        if (^{sr_word, sin}) begin
                            par_bad = 1'b1;
                        end else begin
                            frame_done = 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            a          <= '0;
            a_valid    <= 1'b0;
            drop       <= 1'b0;
            overrun    <= 1'b0;
`ifdef BYTE_DESER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            drop    <= 1'b0;
            overrun <= 1'b0;
`ifdef BYTE_DESER_PARITY_EN
            parity_err <= par_bad;
`endif
            if (a_valid && a_ready) begin
                a_valid <= 1'b0;
            end
            if (frame_done) begin
                if (!a_valid || a_ready) begin
                    a       <= sr_word;
                    a_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
            if (sin_valid) begin
                if (sin_sof) begin
                    if (state != IDLE) begin
                        drop <= 1'b1;
                    end
                    state <= SHIFT;
                end else begin
                    case (state)
                        SHIFT: begin
                            if (last_data) begin
`ifdef BYTE_DESER_PARITY_EN
                                state <= PARITY;
`else
                                state <= IDLE;
`endif
                            end
                        end
                        PARITY:  state <= IDLE;
                        default: state <= state;
                    endcase
                end
            end
        end
    end

endmodule
